regfile_wb_sched: RTL and testbench

- Write-back scheduler in front of the 2-bank, 2-write-port register file (even/odd banks, one write per bank per cycle).
- Accepts two valid/ready write-back streams: wb0 is older in program order, wb1 younger.
- Splits same-bank pairs across two cycles and merges same-address pairs, so the register file never sees a bank conflict.
- Sequences the post-reset clear sweep of all 32 registers and exposes a pending-write window so issue logic can stall.

---
 rtl/regfile_wb_sched_pkg.sv | 26 ++
 rtl/regfile_wb_sched_clear_seq.sv | 48 ++++
 rtl/regfile_wb_sched.sv | 199 +++++++++++++++++++
 tb/tb_regfile_wb_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package rf_sched_pkg;

  localparam int RF_DEPTH        = 32;
  localparam int RF_BANKS        = 2;
  localparam int RF_SWEEP_CYCLES = 16;
  localparam int RF_AW           = 5;
  localparam int RF_WIDTH        = 32;

  typedef struct packed {
    logic [RF_AW-1:0]    addr;
    logic [RF_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  // A write to r0 is swallowed when zero-register dropping is enabled.
  function automatic logic wr_dropped(input logic zero_drop, input logic [RF_AW-1:0] addr);
    return zero_drop && (addr == 5'd0);
  endfunction

endpackage

// File: rtl/regfile_wb_sched_clear_seq.sv
// Post-reset clear-sweep counter; present only with REGFILE_WB_SCHED_CLEAR_SWEEP_EN.
`ifdef REGFILE_WB_SCHED_CLEAR_SWEEP_EN
module rf_clear_seq
  import rf_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [3:0] cnt_o,
  output logic       last_o,
  output logic       done_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (en_i && !done_q) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(RF_SWEEP_CYCLES - 1)) begin
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q;
      done_d = done_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == 4'(RF_SWEEP_CYCLES - 1));
  assign done_o = done_q;

endmodule
`endif

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for a 2-bank register file: splits bank conflicts, merges same-address pairs.
// Optional clear sweep after reset is enabled by REGFILE_WB_SCHED_CLEAR_SWEEP_EN.
module regfile_wb_sched
  import rf_sched_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter bit ZERO_REG_DROP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb0_valid_i,
  output logic             wb0_ready_o,
  input  logic [4:0]       wb0_addr_i,
  input  logic [WIDTH-1:0] wb0_data_i,
  input  logic             wb1_valid_i,
  output logic             wb1_ready_o,
  input  logic [4:0]       wb1_addr_i,
  input  logic [WIDTH-1:0] wb1_data_i,
  output logic             rf_we0_o,
  output logic             rf_we1_o,
  output logic [4:0]       rf_wa0_o,
  output logic [4:0]       rf_wa1_o,
  output logic [WIDTH-1:0] rf_wd0_o,
  output logic [WIDTH-1:0] rf_wd1_o,
  output logic             hold_valid_o,
  output logic [4:0]       hold_addr_o,
  output logic             init_done_o
);

  sched_state_e     state_q, state_d;
  logic             we0_q, we0_d, we1_q, we1_d;
  logic [4:0]       wa0_q, wa0_d, wa1_q, wa1_d;
  logic [WIDTH-1:0] wd0_q, wd0_d, wd1_q, wd1_d;
  logic             hold_valid_q, hold_valid_d;
  logic [4:0]       hold_addr_q, hold_addr_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;

  logic acc0_s, acc1_s, drop0_s, drop1_s, same_addr_s, same_bank_s, split_s;

`ifdef REGFILE_WB_SCHED_CLEAR_SWEEP_EN
  localparam sched_state_e RESET_STATE = INIT;
  logic [3:0] sweep_cnt_s;
  logic       sweep_last_s;
  logic       sweep_done_s;

  rf_clear_seq u_clear_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == INIT),
    .cnt_o  (sweep_cnt_s),
    .last_o (sweep_last_s),
    .done_o (sweep_done_s)
  );

  assign init_done_o = sweep_done_s;
`else
  localparam sched_state_e RESET_STATE = RUN;
  assign init_done_o = 1'b1;
`endif

  assign wb0_ready_o = (state_q == RUN);
  assign wb1_ready_o = (state_q == RUN);

  assign acc0_s      = wb0_valid_i && (state_q == RUN);
  assign acc1_s      = wb1_valid_i && (state_q == RUN);
  assign drop0_s     = wr_dropped(ZERO_REG_DROP, wb0_addr_i);
  assign drop1_s     = wr_dropped(ZERO_REG_DROP, wb1_addr_i);
  assign same_addr_s = (wb0_addr_i == wb1_addr_i);
  assign same_bank_s = (wb0_addr_i[0] == wb1_addr_i[0]);
  // A dropped r0 write from wb0 frees port 0, so no deferral is needed.
  assign split_s     = acc0_s && acc1_s && same_bank_s && !same_addr_s && !drop0_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: begin
`ifdef REGFILE_WB_SCHED_CLEAR_SWEEP_EN
        if (sweep_last_s) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        if (split_s) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
        end
      end
      HOLD:    state_d = RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    we0_d        = 1'b0;
    we1_d        = 1'b0;
    wa0_d        = wa0_q;
    wa1_d        = wa1_q;
    wd0_d        = wd0_q;
    wd1_d        = wd1_q;
    hold_valid_d = 1'b0;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    case (state_q)
      INIT: begin
`ifdef REGFILE_WB_SCHED_CLEAR_SWEEP_EN
        we0_d = 1'b1;
        wa0_d = {sweep_cnt_s, 1'b0};
        wd0_d = {WIDTH{1'b0}};
        we1_d = 1'b1;
        wa1_d = {sweep_cnt_s, 1'b1};
        wd1_d = {WIDTH{1'b0}};
`endif
      end
      RUN: begin
        if (acc0_s && acc1_s) begin
          if (same_addr_s || (same_bank_s && drop0_s)) begin
            we0_d = !drop1_s;
            wa0_d = wb1_addr_i;
            wd0_d = wb1_data_i;
          end else if (!same_bank_s) begin
            we0_d = !drop0_s;
            wa0_d = wb0_addr_i;
            wd0_d = wb0_data_i;
            we1_d = !drop1_s;
            wa1_d = wb1_addr_i;
            wd1_d = wb1_data_i;
          end else begin
            we0_d        = 1'b1;
            wa0_d        = wb0_addr_i;
            wd0_d        = wb0_data_i;
            hold_valid_d = 1'b1;
            hold_addr_d  = wb1_addr_i;
            hold_data_d  = wb1_data_i;
          end
        end else if (acc0_s) begin
          we0_d = !drop0_s;
          wa0_d = wb0_addr_i;
          wd0_d = wb0_data_i;
        end else if (acc1_s) begin
          we0_d = !drop1_s;
          wa0_d = wb1_addr_i;
          wd0_d = wb1_data_i;
        end else begin
          we0_d = 1'b0;
        end
      end
      HOLD: begin
        we0_d = !wr_dropped(ZERO_REG_DROP, hold_addr_q);
        wa0_d = hold_addr_q;
        wd0_d = hold_data_q;
      end
      default: begin
        we0_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      we0_q        <= 1'b0;
      we1_q        <= 1'b0;
      wa0_q        <= 5'd0;
      wa1_q        <= 5'd0;
      wd0_q        <= {WIDTH{1'b0}};
      wd1_q        <= {WIDTH{1'b0}};
      hold_valid_q <= 1'b0;
      hold_addr_q  <= 5'd0;
      hold_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      we0_q        <= we0_d;
      we1_q        <= we1_d;
      wa0_q        <= wa0_d;
      wa1_q        <= wa1_d;
      wd0_q        <= wd0_d;
      wd1_q        <= wd1_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign rf_we0_o     = we0_q;
  assign rf_we1_o     = we1_q;
  assign rf_wa0_o     = wa0_q;
  assign rf_wa1_o     = wa1_q;
  assign rf_wd0_o     = wd0_q;
  assign rf_wd1_o     = wd1_q;
  assign hold_valid_o = hold_valid_q;
  assign hold_addr_o  = hold_addr_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: expected rf writes are queued, a monitor checks them.
module tb_regfile_wb_sched;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wb0_valid_i = 1'b0, wb1_valid_i = 1'b0;
  logic         wb0_ready_o, wb1_ready_o;
  logic [4:0]   wb0_addr_i = 5'd0, wb1_addr_i = 5'd0;
  logic [W-1:0] wb0_data_i = 32'd0, wb1_data_i = 32'd0;
  logic         rf_we0_o, rf_we1_o;
  logic [4:0]   rf_wa0_o, rf_wa1_o;
  logic [W-1:0] rf_wd0_o, rf_wd1_o;
  logic         hold_valid_o;
  logic [4:0]   hold_addr_o;
  logic         init_done_o;

  typedef struct {
    logic         we0;
    logic [4:0]   wa0;
    logic [W-1:0] wd0;
    logic         we1;
    logic [4:0]   wa1;
    logic [W-1:0] wd1;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef REGFILE_WB_SCHED_CLEAR_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  regfile_wb_sched #(.WIDTH(W), .ZERO_REG_DROP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid_i(wb0_valid_i), .wb0_ready_o(wb0_ready_o),
    .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
    .wb1_valid_i(wb1_valid_i), .wb1_ready_o(wb1_ready_o),
    .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
    .rf_we0_o(rf_we0_o), .rf_we1_o(rf_we1_o),
    .rf_wa0_o(rf_wa0_o), .rf_wa1_o(rf_wa1_o),
    .rf_wd0_o(rf_wd0_o), .rf_wd1_o(rf_wd1_o),
    .hold_valid_o(hold_valid_o), .hold_addr_o(hold_addr_o),
    .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic we0, input logic [4:0] wa0, input logic [W-1:0] wd0,
                      input logic we1, input logic [4:0] wa1, input logic [W-1:0] wd1);
    exp_t e;
    e.we0 = we0; e.wa0 = wa0; e.wd0 = wd0;
    e.we1 = we1; e.wa1 = wa1; e.wd1 = wd1;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int c = 0; c < 16; c++) begin
      push(1'b1, 5'(2 * c), 32'd0, 1'b1, 5'(2 * c + 1), 32'd0);
    end
  endtask

  // Monitor: every cycle with a write enable must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (rf_we0_o || rf_we1_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {22'd0, rf_we0_o, rf_wa0_o, rf_we1_o, rf_wa1_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("we0", 32'(rf_we0_o), 32'(e.we0));
        chk("we1", 32'(rf_we1_o), 32'(e.we1));
        if (e.we0) begin
          chk("wa0", 32'(rf_wa0_o), 32'(e.wa0));
          chk("wd0", rf_wd0_o, e.wd0);
        end
        if (e.we1) begin
          chk("wa1", 32'(rf_wa1_o), 32'(e.wa1));
          chk("wd1", rf_wd1_o, e.wd1);
        end
      end
    end
  end

  task automatic wait_init();
    if (SWEEP) begin
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk); #1;
        chk("init_done", 32'(init_done_o), (k == 16) ? 32'd1 : 32'd0);
        chk("ready_init", 32'({wb0_ready_o, wb1_ready_o}), (k == 16) ? 32'd3 : 32'd0);
      end
    end else begin
      @(negedge clk); #1;
      chk("init_done", 32'(init_done_o), 32'd1);
      chk("ready_init", 32'({wb0_ready_o, wb1_ready_o}), 32'd3);
    end
  endtask

  task automatic send(input logic v0, input logic [4:0] a0, input logic [W-1:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [W-1:0] d1);
    chk("ready_pre", 32'({wb0_ready_o, wb1_ready_o}), 32'd3);
    wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
    wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
    @(posedge clk); #1;
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'({rf_we0_o, rf_we1_o}), 32'd0);
    chk({tag, "_wa"}, 32'({rf_wa0_o, rf_wa1_o}), 32'd0);
    chk({tag, "_wd0"}, rf_wd0_o, 32'd0);
    chk({tag, "_hold"}, 32'({hold_valid_o, hold_addr_o}), 32'd0);
    chk({tag, "_done"}, 32'(init_done_o), SWEEP ? 32'd0 : 32'd1);
    chk({tag, "_ready"}, 32'(wb0_ready_o), SWEEP ? 32'd0 : 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    if (SWEEP) push_sweep();
    rst_n = 1'b1;
    wait_init();
    @(posedge clk); #1;

    // Different banks: both ports in one cycle.
    push(1'b1, 5'd4, 32'hA, 1'b1, 5'd7, 32'hB);
    send(1'b1, 5'd4, 32'hA, 1'b1, 5'd7, 32'hB);
    chk("diffbank_hold", 32'(hold_valid_o), 32'd0);

    // Same bank, different address: split over two cycles.
    push(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 32'd0);
    push(1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 32'd0);
    send(1'b1, 5'd4, 32'h11, 1'b1, 5'd6, 32'h22);
    chk("split_hold_v", 32'(hold_valid_o), 32'd1);
    chk("split_hold_a", 32'(hold_addr_o), 32'd6);
    chk("split_ready", 32'({wb0_ready_o, wb1_ready_o}), 32'd0);
    @(posedge clk); #1;
    chk("split_hold_clr", 32'(hold_valid_o), 32'd0);
    chk("split_ready_back", 32'({wb0_ready_o, wb1_ready_o}), 32'd3);

    // Same address: younger wins on port 0.
    push(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
    send(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
    chk("merge_hold", 32'(hold_valid_o), 32'd0);

    // wb0 to r0 with same-bank wb1: r0 dropped, wb1 straight to port 0.
    push(1'b1, 5'd2, 32'h66, 1'b0, 5'd0, 32'd0);
    send(1'b1, 5'd0, 32'h55, 1'b1, 5'd2, 32'h66);
    chk("zero_hold", 32'(hold_valid_o), 32'd0);
    chk("zero_ready", 32'({wb0_ready_o, wb1_ready_o}), 32'd3);

    // Single requests: wb1 alone uses port 0; a lone r0 write produces nothing.
    push(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    send(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    send(1'b1, 5'd0, 32'h44, 1'b0, 5'd0, 32'd0);
    push(1'b1, 5'd13, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    send(1'b1, 5'd13, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset during HOLD: the deferred write must never appear.
    push(1'b1, 5'd8, 32'h77, 1'b0, 5'd0, 32'd0);
    send(1'b1, 5'd8, 32'h77, 1'b1, 5'd10, 32'h88);
    chk("rsthold_hold_v", 32'(hold_valid_o), 32'd1);
    chk("rsthold_hold_a", 32'(hold_addr_o), 32'd10);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #1;
    if (SWEEP) push_sweep();
    rst_n = 1'b1;
    wait_init();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
